// File: rtl/triangle_sweep_controller.sv
// Sequencer for one triangle generator: prescaled enable strobe, clean restart per sweep,
// period counting, one-shot or free-running. Optional pause input under TRI_SWEEP_PAUSE_EN.
module triangle_sweep_controller #(
    parameter int N          = 8,
    parameter int PRESCALE_W = 16,
    parameter int CYCLE_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
`ifdef TRI_SWEEP_PAUSE_EN
    input  logic                  pause,
`endif
    input  logic                  continuous,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [CYCLE_W-1:0]    num_cycles,
    input  logic [N-1:0]          tri_value,
    output logic                  tri_ena,
    output logic                  tri_rst,
    output logic                  busy,
    output logic                  done,
    output logic [CYCLE_W-1:0]    cycles_done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_RUN    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam logic [N-1:0]          TRI_MAX    = {N{1'b1}};
    localparam logic [N-1:0]          TRI_ZERO   = {N{1'b0}};
    localparam logic [N-1:0]          TRI_ONE    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [PRESCALE_W-1:0] PRESC_ZERO = {PRESCALE_W{1'b0}};
    localparam logic [PRESCALE_W-1:0] PRESC_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};
    localparam logic [CYCLE_W-1:0]    CYC_ZERO   = {CYCLE_W{1'b0}};
    localparam logic [CYCLE_W-1:0]    CYC_ONE    = {{(CYCLE_W-1){1'b0}}, 1'b1};

    state_t                  r_state;
    logic [PRESCALE_W-1:0]   r_presc;
    logic                    r_dir_down;
    logic                    r_continuous;
    logic [PRESCALE_W-1:0]   r_prescale;
    logic [CYCLE_W-1:0]      r_num_cycles;
    logic                    r_tri_ena;
    logic                    r_tri_rst;
    logic                    r_busy;
    logic                    r_done;
    logic [CYCLE_W-1:0]      r_cycles_done;

    state_t                  w_state;
    logic [PRESCALE_W-1:0]   w_presc;
    logic                    w_dir_down;
    logic                    w_continuous;
    logic [PRESCALE_W-1:0]   w_prescale;
    logic [CYCLE_W-1:0]      w_num_cycles;
    logic                    w_tri_ena;
    logic                    w_tri_rst;
    logic                    w_busy;
    logic                    w_done;
    logic [CYCLE_W-1:0]      w_cycles_done;
    logic [CYCLE_W-1:0]      w_cycles_inc;
    logic                    w_period_end;
    logic                    w_pause;

`ifdef TRI_SWEEP_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    // A period closes when the strobe visible this cycle steps the generator from 1 down to 0.
    assign w_period_end = r_tri_ena && r_dir_down && (tri_value == TRI_ONE);
    assign w_cycles_inc = r_cycles_done + CYC_ONE;

    // Next-state and next-output logic for the sweep sequencer.
    always_comb begin
        w_state       = r_state;
        w_presc       = r_presc;
        w_dir_down    = r_dir_down;
        w_continuous  = r_continuous;
        w_prescale    = r_prescale;
        w_num_cycles  = r_num_cycles;
        w_tri_ena     = 1'b0;
        w_tri_rst     = 1'b0;
        w_busy        = r_busy;
        w_done        = 1'b0;
        w_cycles_done = r_cycles_done;

        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (start && !stop) begin
                    w_continuous  = continuous;
                    w_prescale    = prescale;
                    w_num_cycles  = num_cycles;
                    w_cycles_done = CYC_ZERO;
                    w_tri_rst     = 1'b1;
                    w_busy        = 1'b1;
                    w_state       = ST_CLEAR;
                end else begin
                    w_state = ST_IDLE;
                end
            end

            ST_CLEAR: begin
                // The CLEAR cycle already counts as prescaler slot 0, so the first strobe
                // lands prescale cycles after RUN is entered.
                w_dir_down = 1'b0;
                w_presc    = PRESC_ZERO;
                if (stop) begin
                    w_state = ST_IDLE;
                    w_busy  = 1'b0;
                end else if (!r_continuous && (r_num_cycles == CYC_ZERO)) begin
                    w_state = ST_FINISH;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                end else begin
                    w_state = ST_RUN;
                    w_busy  = 1'b1;
                    if (r_prescale == PRESC_ZERO) begin
                        w_tri_ena = 1'b1;
                    end else begin
                        w_presc = PRESC_ONE;
                    end
                end
            end

            ST_RUN: begin
                if (stop) begin
                    w_state = ST_IDLE;
                    w_busy  = 1'b0;
                end else begin
                    if (r_tri_ena) begin
                        if (tri_value == TRI_MAX) begin
                            w_dir_down = 1'b1;
                        end else if (tri_value == TRI_ZERO) begin
                            w_dir_down = 1'b0;
                        end else begin
                            w_dir_down = r_dir_down;
                        end
                    end else begin
                        w_dir_down = r_dir_down;
                    end

                    if (w_period_end) begin
                        w_cycles_done = w_cycles_inc;
                        if (!r_continuous && (w_cycles_inc == r_num_cycles)) begin
                            w_state = ST_FINISH;
                            w_done  = 1'b1;
                            w_busy  = 1'b0;
                        end else begin
                            w_state = ST_RUN;
                        end
                    end else begin
                        w_state = ST_RUN;
                    end

                    if (w_state != ST_RUN) begin
                        w_presc = PRESC_ZERO;
                    end else if (w_pause) begin
                        w_presc = r_presc;
                    end else if (r_presc == r_prescale) begin
                        w_tri_ena = 1'b1;
                        w_presc   = PRESC_ZERO;
                    end else begin
                        w_presc = r_presc + PRESC_ONE;
                    end
                end
            end

            ST_FINISH: begin
                w_state = ST_IDLE;
                w_busy  = 1'b0;
            end

            default: begin
                w_state = ST_IDLE;
                w_busy  = 1'b0;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_presc       <= PRESC_ZERO;
            r_dir_down    <= 1'b0;
            r_continuous  <= 1'b0;
            r_prescale    <= PRESC_ZERO;
            r_num_cycles  <= CYC_ZERO;
            r_tri_ena     <= 1'b0;
            r_tri_rst     <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_cycles_done <= CYC_ZERO;
        end else begin
            r_state       <= w_state;
            r_presc       <= w_presc;
            r_dir_down    <= w_dir_down;
            r_continuous  <= w_continuous;
            r_prescale    <= w_prescale;
            r_num_cycles  <= w_num_cycles;
            r_tri_ena     <= w_tri_ena;
            r_tri_rst     <= w_tri_rst;
            r_busy        <= w_busy;
            r_done        <= w_done;
            r_cycles_done <= w_cycles_done;
        end
    end

    assign tri_ena     = r_tri_ena;
    assign tri_rst     = r_tri_rst;
    assign busy        = r_busy;
    assign done        = r_done;
    assign cycles_done = r_cycles_done;

endmodule

// File: doc/triangle_sweep_controller.md
Name: triangle_sweep_controller

Overview:
- Sequences one triangle generator (N-bit up/down counter with clk, synchronous rst, ena) for LED/PWM sweep use.
- Derives the generator's ena strobe from a programmable prescaler and issues a clean restart before each sweep.
- Counts completed triangle periods. Runs a fixed number of periods (one-shot) or free-runs (continuous).
- Sits between the software/config registers and the generator instance; tri_value feeds back from the generator output.

Parameters:
- N, 8, triangle width; must match the generator's N; one period = 2*(2^N-1) ena pulses.
- PRESCALE_W, 16, prescaler width.
- CYCLE_W, 8, period-count width.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin a sweep; sampled only in IDLE
- stop  input  1  abort request; level-sensitive
- continuous  input  1  1 = free-run, 0 = one-shot; latched at start
- prescale  input  PRESCALE_W  ena period minus 1; latched at start
- num_cycles  input  CYCLE_W  periods per one-shot sweep; latched at start
- tri_value  input  N  generator output (feedback)
- tri_ena  output  1  registered enable to generator
- tri_rst  output  1  registered synchronous reset to generator
- busy  output  1  high in CLEAR and RUN
- done  output  1  one-cycle pulse at one-shot completion
- cycles_done  output  CYCLE_W  completed periods in the current sweep

Behaviour:
- All outputs registered. Reset values: tri_ena=0, tri_rst=1, busy=0, done=0, cycles_done=0, state=IDLE, prescaler=0, dir=up.
- tri_rst=1 at reset clears the generator on the first edge after rst release; IDLE drives tri_rst=0 from the next cycle.
- IDLE: tri_ena=0.
  - start=1 and stop=0: latch config, cycles_done=0, go CLEAR.
  - stop=1: has priority; start is ignored.
- CLEAR: one cycle.
  - tri_rst=1, prescaler=0, dir=up.
  - Next state: FINISH if one-shot with num_cycles==0 (no ena issued); otherwise RUN.
- RUN:
  - Prescaler counts 0..prescale. On reaching prescale, tri_ena=1 for one cycle and the prescaler returns to 0. prescale=0 gives ena every cycle.
  - Latency: start sampled at cycle T → tri_rst high at T+1 → first tri_ena at T+2+prescale.
- Direction tracking, evaluated on each issued ena:
  - tri_value==2^N-1: set dir=down.
  - tri_value==0: set dir=up.
- Period completion: an ena is issued while tri_value==1 and dir==down. On completion, cycles_done increments.
  - One-shot: if the new count equals num_cycles, go FINISH. No further ena is issued, and the generator rests at 0.
  - Continuous: cycles_done wraps modulo 2^CYCLE_W; never finishes.
- FINISH: one cycle. done=1, busy=0, tri_ena=0; then IDLE. cycles_done holds its value until the next start.
- stop=1 in CLEAR or RUN:
  - Next state IDLE and tri_ena=0 next cycle; no done pulse.
  - The generator holds its current value; cycles_done holds.
- start while busy: ignored. Config inputs changing mid-sweep: no effect.
- Async rst mid-sweep: immediate return to reset values, including tri_rst=1.

Optional Feature:
- Macro: TRI_SWEEP_PAUSE_EN.
- Defined:
  - Adds input pause (1 bit).
  - While pause=1 in RUN: prescaler holds, tri_ena=0, state and counters hold.
  - Release resumes the prescaler from its held count.
  - stop overrides pause; pause is ignored outside RUN.
- Undefined: no pause port; RUN never stalls.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → outputs immediately tri_ena=0, tri_rst=1, busy=0, done=0, cycles_done=0; tri_rst=0 one cycle after release.
- One-shot, N=3, prescale=0, num_cycles=2, start at T:
  - tri_rst=1 at T+1.
  - tri_ena high T+2..T+29 (28 pulses).
  - cycles_done=1 at T+16, 2 at T+30.
  - done=1 only at T+30; busy low from T+30.
- Prescale: N=3, prescale=3, num_cycles=1 → tri_ena every 4th cycle, first at T+5; 14 pulses total; done once.
- Continuous: N=3, prescale=0, CYCLE_W=2 → cycles_done 1,2,3,0,1 at 14-pulse intervals; done never asserts.
- Stop mid-RUN at tri_value=5 → tri_ena=0 from next cycle, tri_value stays 5, no done, back in IDLE; start during RUN ignored; start+stop together in IDLE ignored.
- num_cycles=0 one-shot → CLEAR then FINISH, done at T+2, zero ena pulses; with TRI_SWEEP_PAUSE_EN, 10-cycle pause mid-RUN lengthens the sweep by exactly 10 cycles.
